// File: rtl/pidctrl_mc.sv
// Multi-channel PID motor-drive controller: one shared datapath walks the channels
// one per cycle into shadow registers, then publishes all mot_set values at once.
module pidctrl_mc #(
   parameter int NCH     = 4,
   parameter int W       = 16,
   parameter int GW      = 8,
   parameter int FRAC    = 4,
   parameter int INT_LIM = 8191,
   parameter int OUT_MAX = 4095,
   parameter int OUT_MIN = -4095
)(
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 sample_valid,
   output logic                 ready,
   input  logic [NCH*W-1:0]     rpm_set,
   input  logic [NCH*W-1:0]     rpm_sense,
   input  logic [NCH-1:0]       ch_en,
   input  logic signed [GW-1:0] kp,
   input  logic signed [GW-1:0] ki,
   input  logic signed [GW-1:0] kd,
   input  logic                 clr_ovr,
   output logic [NCH*W-1:0]     mot_set,
   output logic                 mot_valid,
   output logic                 ovr
);
   localparam int AW = W + GW + 6;
   localparam int IW = W + 3;   // integ + e never overflows before the clamp
   localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
   localparam logic [CW-1:0]        LAST = CW'(NCH - 1);
   localparam logic signed [IW-1:0] ILIM = IW'(INT_LIM);
   localparam logic signed [AW-1:0] OMAX = AW'(OUT_MAX);
   localparam logic signed [AW-1:0] OMIN = AW'(OUT_MIN);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
   state_t state, nstate;

   logic [CW-1:0]        ch;
   logic [NCH*W-1:0]     set_h, sense_h;
   logic [NCH-1:0]       en_h;
   logic signed [GW-1:0] kp_h, ki_h, kd_h;
   logic signed [IW-1:0] integ  [NCH];
   logic signed [W:0]    e_prev [NCH];
   logic signed [W-1:0]  shadow [NCH];

   logic signed [W-1:0]  set_c, sense_c;
   logic signed [W:0]    e, ep;
   logic signed [W+1:0]  d;
   logic signed [IW-1:0] isum, inx;
   logic signed [AW-1:0] acc, u, mot_c;
   logic                 hold;

   assign ready   = (state == IDLE);
   assign set_c   = set_h[ch*W +: W];
   assign sense_c = sense_h[ch*W +: W];
   assign e       = $signed({set_c[W-1], set_c}) - $signed({sense_c[W-1], sense_c});
   assign ep      = e_prev[ch];
   assign d       = $signed({e[W], e}) - $signed({ep[W], ep});
   assign isum    = integ[ch] + $signed({{2{e[W]}}, e});
   assign acc     = AW'(kp_h) * AW'(e) + AW'(ki_h) * AW'(inx) + AW'(kd_h) * AW'(d);
   assign u       = acc >>> FRAC;

   always_comb begin
      inx = isum;
      if (isum > ILIM)       inx = ILIM;
      else if (isum < -ILIM) inx = -ILIM;
      mot_c = u;
      if (u > OMAX)      mot_c = OMAX;
      else if (u < OMIN) mot_c = OMIN;
   end

   // Freeze the integrator only while it would push further into saturation.
   assign hold = ((u > OMAX) && !e[W] && (e != '0)) || ((u < OMIN) && e[W]);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= IDLE;
      else         state <= nstate;
   end

   always_comb begin
      nstate = state;
      case (state)
         IDLE:    if (sample_valid) nstate = CALC;
         CALC:    if (ch == LAST)   nstate = DONE;
         DONE:    nstate = IDLE;
         default: nstate = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ch        <= '0;
         set_h     <= '0;
         sense_h   <= '0;
         en_h      <= '0;
         kp_h      <= '0;
         ki_h      <= '0;
         kd_h      <= '0;
         mot_set   <= '0;
         mot_valid <= 1'b0;
         for (int i = 0; i < NCH; i++) begin
            integ[i]  <= '0;
            e_prev[i] <= '0;
            shadow[i] <= '0;
         end
      end else begin
         mot_valid <= 1'b0;
         case (state)
            IDLE: if (sample_valid) begin
               set_h   <= rpm_set;
               sense_h <= rpm_sense;
               en_h    <= ch_en;
               kp_h    <= kp;
               ki_h    <= ki;
               kd_h    <= kd;
               ch      <= '0;
            end
            CALC: begin
               if (en_h[ch]) begin
                  shadow[ch] <= mot_c[W-1:0];
                  e_prev[ch] <= e;
                  if (!hold) integ[ch] <= inx;
               end else begin
                  shadow[ch] <= '0;
                  e_prev[ch] <= '0;
                  integ[ch]  <= '0;
               end
               ch <= ch + 1'b1;
            end
            DONE: begin
               for (int i = 0; i < NCH; i++) mot_set[i*W +: W] <= shadow[i];
               mot_valid <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Overrun flag: a set in the same cycle as a clear takes priority.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)                    ovr <= 1'b0;
      else if (sample_valid && !ready) ovr <= 1'b1;
      else if (clr_ovr)               ovr <= 1'b0;
   end
endmodule

// File: tb/tb_pidctrl_mc.sv
// Scoreboard bench for pidctrl_mc: a behavioural PID model queues expected mot_set
// vectors at acceptance; a negedge monitor pops and compares on mot_valid.
module tb_pidctrl_mc;
   localparam int NCH = 4;
   localparam int W   = 16;
   localparam int GW  = 8;

   logic clk = 1'b0;
   logic resetn = 1'b1;
   logic sample_valid = 1'b0;
   logic ready;
   logic [NCH*W-1:0] rpm_set = '0, rpm_sense = '0;
   logic [NCH-1:0] ch_en = '0;
   logic signed [GW-1:0] kp = '0, ki = '0, kd = '0;
   logic clr_ovr = 1'b0;
   logic [NCH*W-1:0] mot_set;
   logic mot_valid, ovr;

   pidctrl_mc #(.NCH(NCH), .W(W), .GW(GW), .FRAC(4), .INT_LIM(8191),
                .OUT_MAX(4095), .OUT_MIN(-4095)) dut (
      .clk(clk), .resetn(resetn), .sample_valid(sample_valid), .ready(ready),
      .rpm_set(rpm_set), .rpm_sense(rpm_sense), .ch_en(ch_en),
      .kp(kp), .ki(ki), .kd(kd), .clr_ovr(clr_ovr),
      .mot_set(mot_set), .mot_valid(mot_valid), .ovr(ovr));

   always #5 clk = ~clk;

   typedef struct { longint mot[NCH]; int acc; } exp_t;
   exp_t q[$];

   int n_vec = 0, n_err = 0, cyc = 0;
   int sv[NCH], nv[NCH];
   longint integ_m[NCH], ep_m[NCH];
   logic prev_mv = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input longint obs, input longint expv);
      n_vec++;
      if (obs !== expv) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
      end
   endtask

   function automatic longint ms(input int i);
      logic signed [W-1:0] v;
      v = mot_set[i*W +: W];
      return v;
   endfunction

   function automatic void model_clear();
      for (int i = 0; i < NCH; i++) begin integ_m[i] = 0; ep_m[i] = 0; end
   endfunction

   // Independent behavioural PID model, evaluated on accepted samples only.
   function automatic exp_t model_step(input int acc_cyc);
      exp_t r;
      longint e, dd, in, a, u, o;
      r.acc = acc_cyc;
      for (int i = 0; i < NCH; i++) begin
         if (!ch_en[i]) begin
            r.mot[i] = 0; integ_m[i] = 0; ep_m[i] = 0;
         end else begin
            e  = longint'(sv[i]) - longint'(nv[i]);
            dd = e - ep_m[i];
            in = integ_m[i] + e;
            if (in > 8191) in = 8191;
            if (in < -8191) in = -8191;
            a = longint'(kp) * e + longint'(ki) * in + longint'(kd) * dd;
            u = a >>> 4;
            o = (u > 4095) ? 4095 : (u < -4095) ? -4095 : u;
            r.mot[i] = o;
            if (!((u > 4095 && e > 0) || (u < -4095 && e < 0))) integ_m[i] = in;
            ep_m[i] = e;
         end
      end
      return r;
   endfunction

   always @(negedge clk) begin
      exp_t ex;
      if (resetn && mot_valid) begin
         chk("mv_pulse", longint'(prev_mv), 0);
         if (q.size() == 0) chk("unexpected_valid", 1, 0);
         else begin
            ex = q.pop_front();
            chk("latency", cyc - ex.acc, NCH + 1);
            for (int i = 0; i < NCH; i++) chk($sformatf("mot_ch%0d", i), ms(i), ex.mot[i]);
         end
      end
      prev_mv <= mot_valid;
   end

   task automatic drive_inputs();
      for (int i = 0; i < NCH; i++) begin
         rpm_set[i*W +: W]   = W'(sv[i]);
         rpm_sense[i*W +: W] = W'(nv[i]);
      end
   endtask

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic send();
      int t = 0;
      while (!ready && t < 100) begin @(negedge clk); t++; end
      if (!ready) chk("ready_timeout", 0, 1);
      drive_inputs();
      sample_valid = 1'b1;
      @(posedge clk); #1;
      q.push_back(model_step(cyc));
      @(negedge clk);
      sample_valid = 1'b0;
      rpm_set = ~rpm_set;   // post-capture input changes must be ignored
   endtask

   task automatic wait_idle();
      int t = 0;
      while ((q.size() != 0 || !ready) && t < 100) begin @(negedge clk); t++; end
      if (t >= 100) chk("idle_timeout", 1, 0);
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk); resetn = 1'b0;
      q.delete(); model_clear();
      @(negedge clk); resetn = 1'b1;
      @(negedge clk);
   endtask

   task automatic set_e0(input int e0);
      sv = '{e0, 0, 0, 0}; nv = '{0, 0, 0, 0};
   endtask

   initial begin
      int n;
      model_clear();
      #3 resetn = 1'b0;
      @(negedge clk);
      chk("rst_ready", ready, 1);
      chk("rst_valid", mot_valid, 0);
      chk("rst_ovr", ovr, 0);
      chk("rst_mot", longint'(mot_set), 0);
      resetn = 1'b1;
      @(negedge clk);

      // proportional
      kp = 16; ki = 0; kd = 0; ch_en = 4'hF;
      sv = '{1000, 2000, 0, -500}; nv = '{900, 2100, 0, -500};
      send();
      n = 0;
      while (!ready && n < 50) begin n++; @(negedge clk); end
      chk("ready_low_cycles", n, NCH + 1);
      wait_idle();
      chk("p_ch0", ms(0), 100);
      chk("p_ch1", ms(1), -100);
      chk("p_ch2", ms(2), 0);
      chk("p_ch3", ms(3), 0);
      repeat (5) @(negedge clk);
      chk("hold_ch1", ms(1), -100);

      // integral and clamp
      do_reset();
      kp = 0; ki = 16; kd = 0; ch_en = 4'hF;
      for (int k = 1; k <= 3; k++) begin
         set_e0(10); send(); wait_idle();
         chk("int_ramp", ms(0), 10 * k);
      end
      for (int k = 0; k < 3; k++) begin
         set_e0(30000); send(); wait_idle();
         chk("int_sat", ms(0), 4095);
      end

      // anti-windup
      do_reset();
      kp = 16; ki = 16; kd = 0;
      for (int k = 0; k < 4; k++) begin
         set_e0(5000); send(); wait_idle();
         chk("aw_sat", ms(0), 4095);
      end
      set_e0(-100); send(); wait_idle();
      chk("aw_exit", ms(0), -200);

      // derivative and floor rounding
      do_reset();
      kp = 0; ki = 0; kd = 16;
      set_e0(0);  send(); wait_idle(); chk("d_0", ms(0), 0);
      set_e0(50); send(); wait_idle(); chk("d_50", ms(0), 50);
      set_e0(50); send(); wait_idle(); chk("d_flat", ms(0), 0);
      kp = 1; kd = 0;
      set_e0(-1); send(); wait_idle(); chk("floor_neg", ms(0), -1);

      // overrun: second sample dropped, only the first is expected
      do_reset();
      kp = 16; ki = 16; kd = 0; ch_en = 4'hF;
      sv = '{100, 200, 300, 400}; nv = '{0, 0, 0, 0};
      send();
      @(negedge clk);
      rpm_set = {NCH{16'sd7777}}; kp = 99; sample_valid = 1'b1;
      @(negedge clk);
      sample_valid = 1'b0; kp = 16;
      chk("ovr_set", ovr, 1);
      wait_idle();
      chk("ovr_sticky", ovr, 1);
      clr_ovr = 1'b1; @(negedge clk); clr_ovr = 1'b0;
      chk("ovr_clr", ovr, 0);
      send();
      sample_valid = 1'b1; clr_ovr = 1'b1;
      @(negedge clk);
      sample_valid = 1'b0; clr_ovr = 1'b0;
      chk("ovr_set_wins", ovr, 1);
      wait_idle();
      clr_ovr = 1'b1; @(negedge clk); clr_ovr = 1'b0;

      // channel enable
      ch_en = 4'b1011; send(); wait_idle();
      chk("en_off", ms(2), 0);
      ch_en = 4'hF; send(); wait_idle();
      chk("en_restart", ms(2), 600);

      // random batch through the scoreboard
      for (int k = 0; k < 8; k++) begin
         kp = GW'($urandom_range(0, 255)); ki = GW'($urandom_range(0, 255));
         kd = GW'($urandom_range(0, 255)); ch_en = NCH'($urandom_range(0, 15));
         for (int i = 0; i < NCH; i++) begin
            sv[i] = int'($urandom_range(0, 40000)) - 20000;
            nv[i] = int'($urandom_range(0, 40000)) - 20000;
         end
         send();
      end
      wait_idle();

      // async reset while channel 2 is being computed
      kp = 16; ki = 0; kd = 0; ch_en = 4'hF;
      sv = '{300, 300, 300, 300}; nv = '{0, 0, 0, 0};
      send(); wait_idle();
      send();
      @(negedge clk); @(negedge clk);
      resetn = 1'b0; #1;
      chk("mid_rst_ready", ready, 1);
      chk("mid_rst_valid", mot_valid, 0);
      for (int i = 0; i < NCH; i++) chk("mid_rst_mot", ms(i), 0);
      q.delete(); model_clear();
      @(negedge clk); resetn = 1'b1;
      @(negedge clk);
      kp = 0; ki = 16; set_e0(10); send(); wait_idle();
      chk("post_rst_int", ms(0), 10);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
endmodule
